serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the lab's adder blocks. It sits behind a start/done handshake so a stimulus FSM or a board-level switch/LED wrapper can drive it. Results are registered and held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: minuend; sampled on the accepting edge only.
- `b`  in  WIDTH: subtrahend; sampled on the accepting edge only.
- `busy`  out  1: high while an operation is in progress (SHIFT or DONE state).
- `done`  out  1: one-cycle pulse when a result is written.
- `diff`  out  WIDTH: (a − b) mod 2^WIDTH; held between operations.
- `borrow_out`  out  1: final borrow, 1 iff a < b (unsigned).
- `zero`  out  1: 1 iff diff == 0.

## Operation
- FSM states: IDLE → SHIFT → DONE → IDLE.
- **IDLE, with `start` = 1:**
  - Load shift registers `sa` ← a and `sb` ← b.
  - Clear the borrow FF, the bit counter and the partial-result register `sd`.
  - Go to SHIFT.
- **IDLE, with `start` = 0:** stay in IDLE.
- **SHIFT, each cycle:**
  - Inputs to the cell: x = sa[0], y = sb[0], br = borrow FF.
  - d = x ^ y ^ br.
  - br_next = (~x & y) | (~(x ^ y) & br).
  - `sd` shifts right with d entering at the MSB.
  - `sa` and `sb` shift right.
  - Counter increments.
- **SHIFT, last bit:** on the edge where counter == WIDTH−1:
  - Go to DONE.
  - Write `diff` ← {d, sd[WIDTH−1:1]}, `borrow_out` ← br_next, `zero` ← (that value == 0).
  - Assert `done`.
- **DONE:** one cycle, then return to IDLE; `done` deasserts on the exit edge.
- `busy` = 1 in SHIFT and DONE; `busy` = 0 in IDLE.
- `start` is ignored whenever `busy` = 1. Such a request is not queued and does not corrupt the operation in flight.
- Changes on `a`/`b` after the accepting edge have no effect.
- `diff`, `borrow_out` and `zero` change only on the last-bit edge or on reset. Internal shift registers are never visible at the outputs.
- Arithmetic rules:
  - Unsigned; wrap-around modulo 2^WIDTH.
  - `borrow_out` is the only overflow indicator.
  - Equal operands give diff = 0, zero = 1, borrow_out = 0.
- **Reset (in any state, including mid-SHIFT):**
  - Go to IDLE and abort the operation; no `done` is produced.
  - `busy`, `done`, `diff`, `borrow_out` and `zero` are all 0 after the reset edge.
  - Internal registers are cleared.
  - `rst` has priority over `start` on the same edge.

## Timing
- Let edge k be the IDLE edge on which `start` = 1 is sampled.
- `busy` is 1 from after edge k.
- SHIFT processes bits 0..WIDTH−1 on edges k+1..k+WIDTH.
- After edge k+WIDTH: `done` = 1 and `diff`/`borrow_out`/`zero` are valid.
- After edge k+WIDTH+1: `done` = 0, `busy` = 0, state is IDLE.
- Latency from start to done is WIDTH cycles.
- The earliest next accepted start is edge k+WIDTH+2, so back-to-back throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH = 8.
- Reset with `start` = 1 held → `busy`, `done`, `diff`, `borrow_out`, `zero` all 0; no operation starts on the reset edge.
- a = 0x05, b = 0x03, 1-cycle start → `done` pulses exactly 8 cycles after the accepting edge; diff = 0x02, borrow_out = 0, zero = 0; `busy` high for exactly 9 cycles.
- a = 0x03, b = 0x05 → diff = 0xFE, borrow_out = 1, zero = 0. Then a = 0x00, b = 0xFF → diff = 0x01, borrow_out = 1.
- a = 0xA5, b = 0xA5 → diff = 0x00, zero = 1, borrow_out = 0. Then a = 0xFF, b = 0x00 → diff = 0xFF, borrow_out = 0.
- Start with 0x40 − 0x01; at cycle 3 pulse `start` with a = 0x10, b = 0x20 and change the a/b pins → result 0x3F, borrow_out 0, only one `done`. Then a back-to-back start at the earliest legal edge (k+10) → its `done` arrives 8 cycles later.
- Start with 0x05 − 0x03 after a completed 0x03 − 0x05; assert `rst` at SHIFT cycle 4 → outputs 0 on the next edge, no `done` pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor: operands in, registered result and status out.
// The master drives the request and operands; the slave owns busy/done and the result fields.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, through one full-subtractor cell; done pulses WIDTH cycles after the accepting edge.
// start is only honoured in IDLE; requests while busy are dropped, so one operation per WIDTH+2 cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] res;

  // Full-subtractor cell and the value the result register takes on the final bit.
  always_comb begin
    x       = sa[0];
    y       = sb[0];
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
    last    = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
    res     = {d, sd[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_SHIFT;
      S_SHIFT: if (last)      state_nxt = S_DONE;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa             <= '0;
      sb             <= '0;
      sd             <= '0;
      cnt            <= '0;
      br             <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
      bus.zero       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            sd  <= '0;
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        S_SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= res;
          cnt <= cnt + CW'(1);
          br  <= br_next;
          // Result fields are only ever written here, so they hold across idle and in-flight cycles.
          if (last) begin
            bus.diff       <= res;
            bus.borrow_out <= br_next;
            bus.zero       <= (res == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
